// File: rtl/upcount_ctrl.sv
// 8-bit up-counter controller: IDLE/RUN/PAUSE FSM with clock divider, step and clear.
// Optional build macro UPCOUNT_AUTO_STOP_EN pauses RUN when the count reaches 255.
module upcount_ctrl #(
  parameter int unsigned DIV_MAX   = 50000000,
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnRun,
  input  logic       btnStep,
  input  logic       btnClr,
  output logic [7:0] count,
  output logic [1:0] state,
  output logic       wrapPulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_wrap;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic                 w_wrap_nxt;
  logic [CNT_WIDTH-1:0] w_count_inc;
  logic                 w_at_max;

  assign w_count_inc = r_count + CNT_WIDTH'(1);
  assign w_at_max    = (r_count == {CNT_WIDTH{1'b1}});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_div   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_div   <= w_div_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state logic; priority clr > run > step, divider held at 0 outside RUN
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_div_nxt   = '0;
    w_wrap_nxt  = 1'b0;

    if (btnClr) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if (btnRun) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else if (btnStep && (r_state != ST_RUN)) begin
      w_state_nxt = ST_PAUSE;
      w_count_nxt = w_count_inc;
      w_wrap_nxt  = w_at_max;
    end else if (r_state == ST_RUN) begin
      if (r_div == DIV_LAST) begin
        w_count_nxt = w_count_inc;
        w_wrap_nxt  = w_at_max;
`ifdef UPCOUNT_AUTO_STOP_EN
        if (r_count == CNT_WIDTH'(254)) begin
          w_state_nxt = ST_PAUSE;
        end
`else
        w_state_nxt = ST_RUN;
`endif
      end else begin
        w_div_nxt = r_div + DIV_WIDTH'(1);
      end
    end else if (r_state != ST_IDLE && r_state != ST_PAUSE) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign count     = r_count;
  assign state     = r_state;
  assign wrapPulse = r_wrap;

endmodule

// File: doc/upcount_ctrl.md
UPCOUNT_CTRL -- requirements
Module: upcount_ctrl

Interface
REQ-001 SHALL have parameter DIV_MAX, default 50000000, clk cycles per count increment in RUN (legal range 2..2^32-1).
REQ-002 SHALL have parameter DIV_WIDTH, default 32, width of internal divider register (SHALL hold DIV_MAX-1).
REQ-003 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btnRun  input  1  single-cycle pulse (onePulser output), run/pause toggle.
REQ-006 SHALL have port btnStep  input  1  single-cycle pulse, single increment.
REQ-007 SHALL have port btnClr  input  1  single-cycle pulse, clear.
REQ-008 SHALL have port count  output  8  current counter value, registered.
REQ-009 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE (11 never driven).
REQ-010 SHALL have port wrapPulse  output  1  one-cycle pulse on 255->0 wrap, registered.

Function
REQ-011 SHALL implement FSM IDLE/RUN/PAUSE; all outputs driven from registers.
REQ-012 Same-cycle input priority SHALL be btnClr > btnRun > btnStep; lower-priority pulses in that cycle SHALL be discarded.
REQ-013 btnClr in any state SHALL, at that edge, set count=0, divider=0, state=IDLE.
REQ-014 btnRun SHALL move IDLE->RUN, RUN->PAUSE, PAUSE->RUN at the sampling edge.
REQ-015 btnStep in IDLE or PAUSE SHALL increment count by 1 at the sampling edge and set state=PAUSE.
REQ-016 btnStep in RUN SHALL be ignored.
REQ-017 Divider SHALL be 0 in every cycle state!=RUN; in RUN it SHALL increment each cycle, and on divider==DIV_MAX-1 it SHALL return to 0 and count SHALL increment.
REQ-018 First RUN increment SHALL occur DIV_MAX edges after the edge that entered RUN; subsequent increments every DIV_MAX edges.
REQ-019 RUN->PAUSE->RUN SHALL restart the divider from 0 (no partial-period carry).
REQ-020 Increment arithmetic SHALL be modulo 256; wrap 255->0 (step or RUN) SHALL assert wrapPulse for exactly the cycle after the wrapping edge.
REQ-021 wrapPulse SHALL be 0 in all other cycles, including after btnClr.
REQ-022 Inputs held high for multiple cycles SHALL act once per cycle held (no internal edge detection).

Reset
REQ-023 rst high SHALL immediately force count=0, state=IDLE (00), wrapPulse=0, divider=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abort the in-progress divider period; after deassertion block SHALL stay in IDLE until btnRun or btnStep.
REQ-025 Input pulses coincident with the first edge after rst deassertion SHALL be acted on normally.

Configuration
REQ-026 Macro UPCOUNT_AUTO_STOP_EN: when defined, a RUN increment from 254 to 255 SHALL set state=PAUSE at that edge, count held at 255; a subsequent btnRun SHALL resume RUN and wrap normally.
REQ-027 Without UPCOUNT_AUTO_STOP_EN, RUN SHALL continue through 255->0 with no state change; step behaviour SHALL be identical in both builds.

Verification (DIV_MAX=4)
REQ-028 Reset then btnRun pulse at edge 0 -> state=01 after edge 0, count 0->1 at edge 4, 2 at edge 8, 3 at edge 12.
REQ-029 btnStep x3 from IDLE -> count=3, state=10; btnStep in RUN -> count unchanged.
REQ-030 RUN, btnRun at divider=2, btnRun 5 cycles later -> next increment exactly 4 edges after resume edge.
REQ-031 btnClr+btnRun+btnStep same cycle while count=9 in RUN -> count=0, state=00, no increment.
REQ-032 Count=255 in PAUSE, btnStep -> count=0, wrapPulse high one cycle; RUN from 254 with UPCOUNT_AUTO_STOP_EN -> count=255, state=10, no wrap; without macro -> count 255 then 0 with wrapPulse.
REQ-033 rst asserted asynchronously mid-RUN (between edges, count=7) -> count=0, state=00 before next edge; no increment after deassertion without input.
